// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared opcodes, state codes, datapath select encodings and the control bundle
// for the multicycle MIPS controller.
package mc_ctrl_fsm_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 4;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned NXTPC_W  = 2;

    // Instruction opcodes (IR[31:26])
    localparam logic [OPCODE_W-1:0] OP_RR    = 6'b00_0000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b00_0010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b00_0100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b00_0101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b00_1000;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b00_1001;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b00_1100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b00_1101;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b00_1110;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b10_0011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b10_1011;

    // Controller states (state_type)
    typedef logic [STATE_W-1:0] state_type;
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWRBCK = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RREXEC   = 4'd6;
    localparam logic [3:0] S_RRWRBCK  = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_JMP      = 4'd9;
    localparam logic [3:0] S_RIEXEC   = 4'd10;
    localparam logic [3:0] S_RIWRBCK  = 4'd11;

    // Memory address select
    typedef logic mem_addr_sel_t;
    localparam mem_addr_sel_t ADDR_PC     = 1'b0;
    localparam mem_addr_sel_t ADDR_ALUOUT = 1'b1;

    // ALU source A select
    typedef logic alu_srca_sel_t;
    localparam alu_srca_sel_t SRCA_PC = 1'b0;
    localparam alu_srca_sel_t SRCA_RS = 1'b1;

    // ALU source B select
    typedef logic [SRCB_W-1:0] alu_srcb_sel_t;
    localparam alu_srcb_sel_t SRCB_RT     = 2'd0;
    localparam alu_srcb_sel_t SRCB_FOUR   = 2'd1;
    localparam alu_srcb_sel_t SRCB_IMM    = 2'd2;
    localparam alu_srcb_sel_t SRCB_BEQIMM = 2'd3;

    // ALU operation; ALUOP_RR tells the ALU to decode the funct field
    typedef logic [ALUOP_W-1:0] alu_op_t;
    localparam alu_op_t ALUOP_ADD  = 4'd0;
    localparam alu_op_t ALUOP_ADDU = 4'd1;
    localparam alu_op_t ALUOP_SUB  = 4'd2;
    localparam alu_op_t ALUOP_AND  = 4'd4;
    localparam alu_op_t ALUOP_OR   = 4'd5;
    localparam alu_op_t ALUOP_XOR  = 4'd6;
    localparam alu_op_t ALUOP_RR   = 4'd15;

    // Register-file write destination
    typedef logic wreg_dst_sel_t;
    localparam wreg_dst_sel_t WR_RT = 1'b0;
    localparam wreg_dst_sel_t WR_RD = 1'b1;

    // Register-file write data
    typedef logic wrbck_data_sel_t;
    localparam wrbck_data_sel_t WB_ALUOUT  = 1'b0;
    localparam wrbck_data_sel_t WB_MEMDATA = 1'b1;

    // Next PC select
    typedef logic [NXTPC_W-1:0] nxt_pc_sel_t;
    localparam nxt_pc_sel_t NXT_PC4    = 2'd0;
    localparam nxt_pc_sel_t NXT_BRANCH = 2'd1;
    localparam nxt_pc_sel_t NXT_JMP    = 2'd2;

    // Every datapath select and strobe driven by the controller
    typedef struct packed {
        logic            mem_rd;
        logic            mem_wr;
        mem_addr_sel_t   mem_addr_sel;
        logic            ir_write;
        alu_srca_sel_t   alu_srca_sel;
        alu_srcb_sel_t   alu_srcb_sel;
        alu_op_t         alu_op;
        logic            imm_zext;
        logic            reg_write;
        wreg_dst_sel_t   wreg_dst_sel;
        wrbck_data_sel_t wrbck_data_sel;
        logic            pc_write;
        nxt_pc_sel_t     nxt_pc_sel;
    } ctrl_sig_t;

    // All strobes off, all selects at encoding 0
    function automatic ctrl_sig_t ctrl_idle();
        ctrl_sig_t c;
        c = '0;
        return c;
    endfunction

    // States that talk to memory and may stall on mem_ready
    function automatic logic is_mem_state(input state_type s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_ri_alu_dec.sv
// Register-immediate decoder: opcode to ALU op, immediate extension and legality.
module mc_ctrl_fsm_ri_alu_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output alu_op_t             alu_op,
    output logic                imm_zext,
    output logic                legal
);

    // Logical immediates are zero-extended, arithmetic ones sign-extended
    always_comb begin
        alu_op   = ALUOP_ADD;
        imm_zext = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_ADDI:  alu_op = ALUOP_ADD;
            OP_ADDIU: alu_op = ALUOP_ADDU;
            OP_ANDI: begin
                alu_op   = ALUOP_AND;
                imm_zext = 1'b1;
            end
            OP_ORI: begin
                alu_op   = ALUOP_OR;
                imm_zext = 1'b1;
            end
            OP_XORI: begin
                alu_op   = ALUOP_XOR;
                imm_zext = 1'b1;
            end
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit with memory wait states, bus timeout,
// BNE and zero-extended logical immediates.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned TIMEOUT       = 16,
    parameter int unsigned WAIT_W        = 5,
    parameter bit          EN_BNE        = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                mem_addr_sel,
    output logic                ir_write,
    output logic                alu_srca_sel,
    output logic [SRCB_W-1:0]   alu_srcb_sel,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                imm_zext,
    output logic                reg_write,
    output logic                wreg_dst_sel,
    output logic                wrbck_data_sel,
    output logic                pc_write,
    output logic [NXTPC_W-1:0]  nxt_pc_sel,
    output logic                illegal_op,
    output logic                bus_err,
    output logic [STATE_W-1:0]  state
);

    state_type         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_sig_t         ctrl;
    logic              illegal_c;
    logic              bus_err_c;
    logic              mem_ok;
    logic              timeout_hit;
    logic              is_bne;
    alu_op_t           ri_alu_op;
    logic              ri_zext;
    logic              ri_legal;

    mc_ctrl_fsm_ri_alu_dec u_ri_alu_dec (
        .opcode   (opcode),
        .alu_op   (ri_alu_op),
        .imm_zext (ri_zext),
        .legal    (ri_legal)
    );

    // Without the handshake every memory access completes in one cycle
    assign mem_ok      = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));
    assign is_bne      = EN_BNE && (opcode == OP_BNE);

    // State and wait-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, wait counter and per-state control bundle
    always_comb begin
        ctrl      = ctrl_idle();
        state_d   = state_q;
        wait_d    = '0;
        illegal_c = 1'b0;
        bus_err_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_rd       = 1'b1;
                ctrl.mem_addr_sel = ADDR_PC;
                ctrl.alu_srca_sel = SRCA_PC;
                ctrl.alu_srcb_sel = SRCB_FOUR;
                ctrl.alu_op       = ALUOP_ADD;
                ctrl.nxt_pc_sel   = NXT_PC4;
                ctrl.ir_write     = mem_ok;
                ctrl.pc_write     = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_srca_sel = SRCA_PC;
                ctrl.alu_srcb_sel = SRCB_BEQIMM;
                ctrl.alu_op       = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RR:        state_d = S_RREXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JMP;
                    default: begin
                        if (is_bne) begin
                            state_d = S_BEQ;
                        end else if (ri_legal) begin
                            state_d = S_RIEXEC;
                        end else begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADDR: begin
                ctrl.alu_srca_sel = SRCA_RS;
                ctrl.alu_srcb_sel = SRCB_IMM;
                ctrl.alu_op       = ALUOP_ADD;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_addr_sel = ADDR_ALUOUT;
                ctrl.mem_rd       = 1'b1;
                if (mem_ok) state_d = S_MEMWRBCK;
            end
            S_MEMWRBCK: begin
                ctrl.reg_write      = 1'b1;
                ctrl.wreg_dst_sel   = WR_RT;
                ctrl.wrbck_data_sel = WB_MEMDATA;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_addr_sel = ADDR_ALUOUT;
                ctrl.mem_wr       = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_RREXEC: begin
                ctrl.alu_srca_sel = SRCA_RS;
                ctrl.alu_srcb_sel = SRCB_RT;
                ctrl.alu_op       = ALUOP_RR;
                state_d = S_RRWRBCK;
            end
            S_RRWRBCK: begin
                ctrl.reg_write      = 1'b1;
                ctrl.wreg_dst_sel   = WR_RD;
                ctrl.wrbck_data_sel = WB_ALUOUT;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_srca_sel = SRCA_RS;
                ctrl.alu_srcb_sel = SRCB_RT;
                ctrl.alu_op       = ALUOP_SUB;
                ctrl.nxt_pc_sel   = NXT_BRANCH;
                ctrl.pc_write     = is_bne ? ~zero : zero;
                state_d = S_FETCH;
            end
            S_JMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.nxt_pc_sel = NXT_JMP;
                state_d = S_FETCH;
            end
            S_RIEXEC: begin
                ctrl.alu_srca_sel = SRCA_RS;
                ctrl.alu_srcb_sel = SRCB_IMM;
                ctrl.alu_op       = ri_alu_op;
                ctrl.imm_zext     = ri_zext;
                state_d = S_RIWRBCK;
            end
            S_RIWRBCK: begin
                ctrl.reg_write      = 1'b1;
                ctrl.wreg_dst_sel   = WR_RT;
                ctrl.wrbck_data_sel = WB_ALUOUT;
                ctrl.imm_zext       = ri_zext;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Stalled memory state: count, or abort to a fresh fetch on timeout
        if (is_mem_state(state_q) && !mem_ok) begin
            if (timeout_hit) begin
                bus_err_c = 1'b1;
                state_d   = S_FETCH;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
    end

    // Strobes are forced low while reset is held; selects pass through
    always_comb begin
        mem_rd         = ctrl.mem_rd    & ~reset;
        mem_wr         = ctrl.mem_wr    & ~reset;
        ir_write       = ctrl.ir_write  & ~reset;
        reg_write      = ctrl.reg_write & ~reset;
        pc_write       = ctrl.pc_write  & ~reset;
        illegal_op     = illegal_c      & ~reset;
        bus_err        = bus_err_c      & ~reset;
        mem_addr_sel   = ctrl.mem_addr_sel;
        alu_srca_sel   = ctrl.alu_srca_sel;
        alu_srcb_sel   = ctrl.alu_srcb_sel;
        alu_op         = ctrl.alu_op;
        imm_zext       = ctrl.imm_zext;
        wreg_dst_sel   = ctrl.wreg_dst_sel;
        wrbck_data_sel = ctrl.wrbck_data_sel;
        nxt_pc_sel     = ctrl.nxt_pc_sel;
        state          = state_q;
    end

endmodule
